// File: rtl/pong_engine.sv
// pong_engine: frame-ticked Pong game state (ball, paddles, scores, match FSM) for a separate renderer.
// Define AI_PADDLE_EN to have p2 track the ball instead of following buttons[3:2].
module pong_engine #(
  parameter int SCREENWIDTH     = 640,
  parameter int SCREENHEIGHT    = 480,
  parameter int BORDERTHICKNESS = 15,
  parameter int BALLSIZE        = 15,
  parameter int PADDLEWIDTH     = 15,
  parameter int PADDLEHEIGHT    = 100,
  parameter int P1X             = 40,
  parameter int P2X             = 585,
  parameter int PADDLESTEP      = 5,
  parameter int VX_INIT         = 2,
  parameter int VX_MAX          = 8,
  parameter int VY              = 5,
  parameter int WIN_SCORE       = 11,
  parameter int SERVE_FRAMES    = 60,
  parameter int CW              = 10,
  parameter int SCW             = 5
) (
  input  logic           CLK,
  input  logic           reset_n,
  input  logic           frame_tick,
  input  logic           start,
  input  logic [3:0]     buttons,
  output logic [CW-1:0]  ball_x,
  output logic [CW-1:0]  ball_y,
  output logic [CW-1:0]  p1_y,
  output logic [CW-1:0]  p2_y,
  output logic [SCW-1:0] score1,
  output logic [SCW-1:0] score2,
  output logic [2:0]     state,
  output logic [1:0]     winner,
  output logic           hit_pulse,
  output logic           score_pulse
);
  localparam int SW = CW + 2;
  localparam logic [CW-1:0] CX   = CW'((SCREENWIDTH - BALLSIZE) / 2);
  localparam logic [CW-1:0] CY   = CW'((SCREENHEIGHT - BALLSIZE) / 2);
  localparam logic [CW-1:0] PC   = CW'((SCREENHEIGHT - PADDLEHEIGHT) / 2);
  localparam logic [CW-1:0] PTOP = CW'(BORDERTHICKNESS);
  localparam logic [CW-1:0] PBOT = CW'(SCREENHEIGHT - BORDERTHICKNESS - PADDLEHEIGHT);
  localparam logic [CW-1:0] STEP = CW'(PADDLESTEP);
  localparam logic [CW-1:0] VXI  = CW'(VX_INIT);
  localparam logic [CW-1:0] VXM  = CW'(VX_MAX);
  localparam logic [CW-1:0] SF   = CW'(SERVE_FRAMES);
  localparam logic [CW-1:0] P1R  = CW'(P1X + PADDLEWIDTH);
  localparam logic [CW-1:0] P2L  = CW'(P2X - BALLSIZE);
  localparam logic [CW-1:0] YTOP = CW'(BORDERTHICKNESS);
  localparam logic [CW-1:0] YBOT = CW'(SCREENHEIGHT - BORDERTHICKNESS - BALLSIZE);
  localparam logic [CW-1:0] VYU  = CW'(VY);
  localparam logic [SCW-1:0] WIN = SCW'(WIN_SCORE);
  localparam logic signed [SW-1:0] S_B   = SW'(BORDERTHICKNESS);
  localparam logic signed [SW-1:0] S_BS  = SW'(BALLSIZE);
  localparam logic signed [SW-1:0] S_PH  = SW'(PADDLEHEIGHT);
  localparam logic signed [SW-1:0] S_VY  = SW'(VY);
  localparam logic signed [SW-1:0] S_P1R = SW'(P1X + PADDLEWIDTH);
  localparam logic signed [SW-1:0] S_P2X = SW'(P2X);
  localparam logic signed [SW-1:0] S_HB  = SW'(SCREENHEIGHT - BORDERTHICKNESS);
  localparam logic signed [SW-1:0] S_WB  = SW'(SCREENWIDTH - BORDERTHICKNESS);

  typedef enum logic [2:0] {IDLE = 3'd0, SERVE = 3'd1, PLAY = 3'd2, OVER = 3'd3} st_t;

  st_t state_q, state_d;
  logic [CW-1:0] bx_q, bx_d, by_q, by_d, p1_q, p1_d, p2_q, p2_d, vx_q, vx_d, cnt_q, cnt_d;
  logic [SCW-1:0] s1_q, s1_d, s2_q, s2_d, s1n, s2n;
  logic [1:0] win_q, win_d;
  logic dxr_q, dxr_d, dyd_q, dyd_d, hit_q, hit_d, scp_q, scp_d;
  logic signed [SW-1:0] x, y, v, a, b, nx, ny;
  logic [CW-1:0] nxu, nyu;
  logic top, bot, hit1, hit2, goal1, goal2, p2_up, p2_dn;

  function automatic logic [CW-1:0] pmove(input logic [CW-1:0] p, input logic up, input logic dn);
    logic [CW-1:0] ru, rd;
    ru = p - PTOP;
    rd = PBOT - p;
    return (up && !dn) ? p - ((ru < STEP) ? ru : STEP) :
           (dn && !up) ? p + ((rd < STEP) ? rd : STEP) : p;
  endfunction

`ifdef AI_PADDLE_EN
  logic [CW-1:0] bc, pc;
  assign bc = by_q + CW'(BALLSIZE / 2);
  assign pc = p2_q + CW'(PADDLEHEIGHT / 2);
  assign p2_up = bc + STEP < pc;
  assign p2_dn = bc > pc + STEP;
`else
  assign p2_up = buttons[3];
  assign p2_dn = buttons[2];
`endif

  // Signed, two-bit-wider copies so off-screen candidates compare without wrapping
  assign x   = $signed({2'b00, bx_q});
  assign y   = $signed({2'b00, by_q});
  assign v   = $signed({2'b00, vx_q});
  assign a   = $signed({2'b00, p1_q});
  assign b   = $signed({2'b00, p2_q});
  assign nx  = dxr_q ? x + v : x - v;
  assign ny  = dyd_q ? y + S_VY : y - S_VY;
  assign nxu = dxr_q ? bx_q + vx_q : bx_q - vx_q;
  assign nyu = dyd_q ? by_q + VYU : by_q - VYU;
  assign top = ny <= S_B;
  assign bot = ny + S_BS >= S_HB;
  assign hit1 = !dxr_q && x >= S_P1R && nx <= S_P1R && y + S_BS > a && y < a + S_PH;
  assign hit2 = dxr_q && x + S_BS <= S_P2X && nx + S_BS >= S_P2X && y + S_BS > b && y < b + S_PH;
  assign goal2 = !hit1 && !hit2 && nx <= S_B;
  assign goal1 = !hit1 && !hit2 && nx + S_BS >= S_WB;
  assign s1n = s1_q + 1'b1;
  assign s2n = s2_q + 1'b1;

  always_ff @(posedge CLK or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;

  always_comb begin
    state_d = state_q;
    if (frame_tick)
      case (state_q)
        IDLE, OVER: state_d = start ? SERVE : state_q;
        SERVE:      state_d = (cnt_q <= CW'(1)) ? PLAY : SERVE;
        PLAY:       state_d = ((goal1 && s1n == WIN) || (goal2 && s2n == WIN)) ? OVER :
                              (goal1 || goal2) ? SERVE : PLAY;
        default:    state_d = IDLE;
      endcase
  end

  always_comb begin
    state       = state_q;
    ball_x      = bx_q;
    ball_y      = by_q;
    p1_y        = p1_q;
    p2_y        = p2_q;
    score1      = s1_q;
    score2      = s2_q;
    winner      = win_q;
    hit_pulse   = hit_q;
    score_pulse = scp_q;
  end

  always_comb begin
    bx_d  = bx_q;
    by_d  = by_q;
    p1_d  = p1_q;
    p2_d  = p2_q;
    vx_d  = vx_q;
    cnt_d = cnt_q;
    dxr_d = dxr_q;
    dyd_d = dyd_q;
    s1_d  = s1_q;
    s2_d  = s2_q;
    win_d = win_q;
    hit_d = 1'b0;
    scp_d = 1'b0;
    if (frame_tick) begin
      if ((state_q == IDLE || state_q == OVER) && start) begin
        s1_d  = '0;
        s2_d  = '0;
        win_d = 2'd0;
        dxr_d = 1'b1;
        dyd_d = 1'b1;
        cnt_d = SF;
        bx_d  = CX;
        by_d  = CY;
      end
      if (state_q == SERVE || state_q == PLAY) begin
        p1_d = pmove(p1_q, buttons[1], buttons[0]);
        p2_d = pmove(p2_q, p2_up, p2_dn);
      end
      if (state_q == SERVE) begin
        cnt_d = cnt_q - 1'b1;
        vx_d  = VXI;
      end
      if (state_q == PLAY) begin
        by_d  = top ? YTOP : bot ? YBOT : nyu;
        dyd_d = top | (dyd_q & ~bot);
        bx_d  = hit1 ? P1R : hit2 ? P2L : nxu;
        dxr_d = hit1 | (dxr_q & ~hit2);
        hit_d = hit1 | hit2;
        vx_d  = (hit1 || hit2) ? ((vx_q >= VXM) ? VXM : vx_q + 1'b1) : vx_q;
        // A goal recentres the ball and serves toward the player who conceded
        if (goal1 || goal2) begin
          scp_d = 1'b1;
          s1_d  = goal1 ? s1n : s1_q;
          s2_d  = goal2 ? s2n : s2_q;
          win_d = (goal1 && s1n == WIN) ? 2'd1 : (goal2 && s2n == WIN) ? 2'd2 : 2'd0;
          bx_d  = CX;
          by_d  = CY;
          dxr_d = goal1;
          dyd_d = 1'b1;
          cnt_d = SF;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge reset_n)
    if (!reset_n) begin
      bx_q  <= CX;
      by_q  <= CY;
      p1_q  <= PC;
      p2_q  <= PC;
      vx_q  <= VXI;
      cnt_q <= '0;
      dxr_q <= 1'b1;
      dyd_q <= 1'b1;
      s1_q  <= '0;
      s2_q  <= '0;
      win_q <= 2'd0;
      hit_q <= 1'b0;
      scp_q <= 1'b0;
    end else begin
      bx_q  <= bx_d;
      by_q  <= by_d;
      p1_q  <= p1_d;
      p2_q  <= p2_d;
      vx_q  <= vx_d;
      cnt_q <= cnt_d;
      dxr_q <= dxr_d;
      dyd_q <= dyd_d;
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      win_q <= win_d;
      hit_q <= hit_d;
      scp_q <= scp_d;
    end
endmodule
